// File: rtl/pacman_tile_pkg.sv
// Shared tile-code and colour-channel types for the map tile renderer.
// Latency: n/a (type definitions only).
// Backpressure: n/a.
package pacman_tile_pkg;

    localparam int TILE_CODE_W = 4;

    typedef enum logic [TILE_CODE_W-1:0] {
        TC_CORNER_LL = 4'h0,
        TC_WALL_UP   = 4'h1,
        TC_WALL_RT   = 4'h2,
        TC_WALL_DN   = 4'h3,
        TC_WALL_LF   = 4'h4,
        TC_CORNER_UL = 4'h5,
        TC_CORNER_UR = 4'h6,
        TC_CORNER_LR = 4'h7,
        TC_EMPTY     = 4'h8,
        TC_CANDY     = 4'h9,
        TC_POWER     = 4'hA,
        TC_GATE      = 4'hB,
        TC_RSVD_C    = 4'hC,
        TC_RSVD_D    = 4'hD,
        TC_RSVD_E    = 4'hE,
        TC_RSVD_F    = 4'hF
    } tile_code_e;

    // Which channel(s) a lit pixel drives; pink is full red plus half blue.
    typedef enum logic [1:0] {
        CH_R    = 2'd0,
        CH_G    = 2'd1,
        CH_B    = 2'd2,
        CH_PINK = 2'd3
    } chan_sel_e;

endpackage

// File: rtl/map_tile_renderer_if.sv
// Pixel request (offset + tile code) and pixel result (RGB + wall flag) bundle.
// Latency: n/a (wiring only).
// Backpressure: none; both directions are valid-only streams.
interface map_tile_renderer_if
    import pacman_tile_pkg::*;
#(
    parameter int TILE_BITS = 3,
    parameter int COLOR_W   = 4
);
    logic                   pix_valid_i;
    logic [TILE_BITS-1:0]   sx;
    logic [TILE_BITS-1:0]   sy;
    logic [TILE_CODE_W-1:0] tile_code;

    logic                   pix_valid_o;
    logic [COLOR_W-1:0]     R;
    logic [COLOR_W-1:0]     G;
    logic [COLOR_W-1:0]     B;
    logic                   wall_px;

    modport master (
        output pix_valid_i, sx, sy, tile_code,
        input  pix_valid_o, R, G, B, wall_px
    );

    modport slave (
        input  pix_valid_i, sx, sy, tile_code,
        output pix_valid_o, R, G, B, wall_px
    );
endinterface

// File: rtl/map_tile_shape.sv
// Decodes one in-tile pixel of a tile code into lit / channel select / wall flag.
// Latency: purely combinational.
// Backpressure: none.
module map_tile_shape
    import pacman_tile_pkg::*;
#(
    parameter int TILE_BITS = 3
) (
    input  tile_code_e           code,
    input  logic [TILE_BITS-1:0] sx,
    input  logic [TILE_BITS-1:0] sy,
    input  logic                 blink_on,
    input  logic                 gate_open,
    output logic                 lit,
    output chan_sel_e            chan_sel,
    output logic                 is_wall
);
    // Centre line of the tile and its neighbours (C-1, C, C+1).
    localparam logic [TILE_BITS-1:0] C   = {1'b1, {(TILE_BITS-1){1'b0}}};
    localparam logic [TILE_BITS-1:0] CM1 = {1'b0, {(TILE_BITS-1){1'b1}}};
    localparam logic [TILE_BITS-1:0] CP1 = {1'b1, {(TILE_BITS-2){1'b0}}, 1'b1};

    logic x_eq, y_eq, x_ge, x_le, y_ge, y_le;
    logic x_near, y_near, x_candy, y_candy;

    assign x_eq    = (sx == C);
    assign y_eq    = (sy == C);
    assign x_ge    = (sx >= C);
    assign x_le    = (sx <= C);
    assign y_ge    = (sy >= C);
    assign y_le    = (sy <= C);
    assign x_near  = (sx >= CM1) && (sx <= CP1);
    assign y_near  = (sy >= CM1) && (sy <= CP1);
    assign x_candy = (sx == CM1) || (sx == C);
    assign y_candy = (sy == CM1) || (sy == C);

    // Shape table: walls/corners are blue centre lines, candy/cookie are blobs, gate is pink.
    always_comb begin
        lit      = 1'b0;
        chan_sel = CH_B;
        is_wall  = 1'b0;
        case (code)
            TC_CORNER_LL: begin
                lit     = (y_eq && x_ge) || (y_le && x_eq);
                is_wall = lit;
            end
            TC_WALL_UP, TC_WALL_DN: begin
                lit     = y_eq;
                is_wall = lit;
            end
            TC_WALL_RT, TC_WALL_LF: begin
                lit     = x_eq;
                is_wall = lit;
            end
            TC_CORNER_UL: begin
                lit     = (y_eq && x_ge) || (y_ge && x_eq);
                is_wall = lit;
            end
            TC_CORNER_UR: begin
                lit     = (y_eq && x_le) || (y_ge && x_eq);
                is_wall = lit;
            end
            TC_CORNER_LR: begin
                lit     = (y_eq && x_le) || (y_le && x_eq);
                is_wall = lit;
            end
            TC_CANDY: begin
                lit      = x_candy && y_candy;
                chan_sel = CH_G;
            end
            TC_POWER: begin
                lit = x_near && y_near && blink_on;
            end
            TC_GATE: begin
                lit      = y_eq && !gate_open;
                chan_sel = CH_PINK;
                is_wall  = lit;
            end
            default: begin
                lit = 1'b0;
            end
        endcase
    end
endmodule

// File: rtl/map_tile_renderer.sv
// Renders one in-tile pixel per clock to RGB with wall flag, gate and blinking power cookies.
// Latency: 2 clocks (S1 input register, S2 decode + output register), 1 pixel/clock.
// Backpressure: none; never stalls, invalid slots produce black.
module map_tile_renderer
    import pacman_tile_pkg::*;
#(
    parameter int TILE_BITS    = 3,
    parameter int COLOR_W      = 4,
    parameter int BLINK_FRAMES = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic frame_start,
    input  logic gate_open,
    map_tile_renderer_if.slave pix
);
    // A single-frame blink period still needs a 1-bit counter to hold its zero.
    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(BLINK_FRAMES - 1);
    localparam logic [COLOR_W-1:0] FULL    = '1;
    localparam logic [COLOR_W-1:0] HALF    = {1'b0, {(COLOR_W-1){1'b1}}};

    logic                 s1_vld;
    logic [TILE_BITS-1:0] s1_sx;
    logic [TILE_BITS-1:0] s1_sy;
    tile_code_e           s1_code;

    logic [CNT_W-1:0]     blink_cnt;
    logic                 blink_on;

    logic                 lit;
    chan_sel_e            chan_sel;
    logic                 is_wall;
    logic                 px_on;

    // Frame-counted blink phase; reset restarts with cookies visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (frame_start) begin
            if (blink_cnt == CNT_MAX) begin
                blink_cnt <= '0;
                blink_on  <= ~blink_on;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    // S1: capture the incoming pixel request.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld  <= 1'b0;
            s1_sx   <= '0;
            s1_sy   <= '0;
            s1_code <= TC_CORNER_LL;
        end else begin
            s1_vld  <= pix.pix_valid_i;
            s1_sx   <= pix.sx;
            s1_sy   <= pix.sy;
            s1_code <= tile_code_e'(pix.tile_code);
        end
    end

    // blink_on is the pre-update value here, so a coincident frame_start affects the next pixel.
    map_tile_shape #(
        .TILE_BITS (TILE_BITS)
    ) u_shape (
        .code      (s1_code),
        .sx        (s1_sx),
        .sy        (s1_sy),
        .blink_on  (blink_on),
        .gate_open (gate_open),
        .lit       (lit),
        .chan_sel  (chan_sel),
        .is_wall   (is_wall)
    );

    assign px_on = s1_vld && lit;

    // S2: register colour; an empty slot is forced black so nothing stale leaks out.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix.pix_valid_o <= 1'b0;
            pix.R           <= '0;
            pix.G           <= '0;
            pix.B           <= '0;
            pix.wall_px     <= 1'b0;
        end else begin
            pix.pix_valid_o <= s1_vld;
            pix.R           <= (px_on && (chan_sel == CH_R || chan_sel == CH_PINK)) ? FULL : '0;
            pix.G           <= (px_on && chan_sel == CH_G) ? FULL : '0;
            pix.B           <= !px_on              ? '0   :
                               (chan_sel == CH_B)  ? FULL :
                               (chan_sel == CH_PINK) ? HALF : '0;
            pix.wall_px     <= s1_vld && is_wall;
        end
    end
endmodule

// File: tb/tb_map_tile_renderer.sv
// Bench for map_tile_renderer: two instances (8-px and 16-px tiles) against a rule-level model.
// Latency: model reproduces the 2-clock pipeline from the tile rules, not the RTL structure.
// Backpressure: none exercised; the design has none.
module tb_map_tile_renderer;
    typedef struct packed {
        logic       wall;
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } px_t;

    logic clk;
    logic rst;
    logic frame_start;
    logic gate_open;

    map_tile_renderer_if #(.TILE_BITS(3), .COLOR_W(4)) p3 ();
    map_tile_renderer_if #(.TILE_BITS(4), .COLOR_W(4)) p4 ();

    map_tile_renderer #(.TILE_BITS(3), .COLOR_W(4), .BLINK_FRAMES(2)) dut3 (
        .clk(clk), .rst(rst), .frame_start(frame_start), .gate_open(gate_open), .pix(p3.slave)
    );
    map_tile_renderer #(.TILE_BITS(4), .COLOR_W(4), .BLINK_FRAMES(1)) dut4 (
        .clk(clk), .rst(rst), .frame_start(frame_start), .gate_open(gate_open), .pix(p4.slave)
    );

    int errors = 0;
    int checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- rule-level model ----------------
    int  tbits [2] = '{3, 4};
    int  bfr   [2] = '{2, 1};
    bit  m_vld [2] = '{0, 0};
    int  m_sx  [2] = '{0, 0};
    int  m_sy  [2] = '{0, 0};
    int  m_code[2] = '{0, 0};
    int  m_cnt [2] = '{0, 0};
    bit  m_on  [2] = '{1, 1};
    bit  exp_vld [2] = '{0, 0};
    px_t exp_px  [2];
    int  exp_code[2] = '{0, 0};
    int  lit3[16];
    int  lit4[16];
    int  base3[16];
    int  base4[16];

    function automatic px_t model_px(int tb, int code, int x, int y, bit bo, bit go);
        int  c;
        bit  on;
        px_t p;
        c  = 1 << (tb - 1);
        p  = '0;
        on = 0;
        case (code)
            0:    on = (y == c && x >= c) || (y <= c && x == c);
            1, 3: on = (y == c);
            2, 4: on = (x == c);
            5:    on = (y == c && x >= c) || (y >= c && x == c);
            6:    on = (y == c && x <= c) || (y >= c && x == c);
            7:    on = (y == c && x <= c) || (y <= c && x == c);
            9:    on = (x == c - 1 || x == c) && (y == c - 1 || y == c);
            10:   on = bo && x >= c - 1 && x <= c + 1 && y >= c - 1 && y <= c + 1;
            11:   on = (y == c) && !go;
            default: on = 0;
        endcase
        if (on) begin
            if (code <= 7) begin
                p.b = 4'd15; p.wall = 1'b1;
            end else if (code == 9) begin
                p.g = 4'd15;
            end else if (code == 10) begin
                p.b = 4'd15;
            end else if (code == 11) begin
                p.r = 4'd15; p.b = 4'(15 / 2); p.wall = 1'b1;
            end
        end
        return p;
    endfunction

    task automatic model_step(int d, bit vld, int x, int y, int code);
        if (rst) begin
            exp_vld[d] = 0;
            exp_px[d]  = '0;
            m_vld[d]   = 0;
            m_cnt[d]   = 0;
            m_on[d]    = 1;
        end else begin
            exp_vld[d]  = m_vld[d];
            exp_px[d]   = m_vld[d] ? model_px(tbits[d], m_code[d], m_sx[d], m_sy[d], m_on[d], gate_open) : '0;
            exp_code[d] = m_code[d];
            if (frame_start) begin
                if (m_cnt[d] == bfr[d] - 1) begin
                    m_cnt[d] = 0;
                    m_on[d]  = !m_on[d];
                end else begin
                    m_cnt[d] = m_cnt[d] + 1;
                end
            end
            m_vld[d]  = vld;
            m_sx[d]   = x;
            m_sy[d]   = y;
            m_code[d] = code;
        end
    endtask

    // Advance the model on the same edge the DUT samples its inputs.
    always @(posedge clk) begin
        model_step(0, p3.pix_valid_i, int'(p3.sx), int'(p3.sy), int'(p3.tile_code));
        model_step(1, p4.pix_valid_i, int'(p4.sx), int'(p4.sy), int'(p4.tile_code));
    end

    // Compare both instances against the model every cycle, away from the active edge.
    always @(negedge clk) begin
        logic [13:0] act, want;
        act  = {p3.pix_valid_o, p3.wall_px, p3.R, p3.G, p3.B};
        want = {exp_vld[0], exp_px[0]};
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL model_t3 t=%0t got=%h want=%h", $time, act, want);
        end
        if (p3.pix_valid_o === 1'b1 && (p3.R | p3.G | p3.B) != 4'd0) lit3[exp_code[0]]++;
        act  = {p4.pix_valid_o, p4.wall_px, p4.R, p4.G, p4.B};
        want = {exp_vld[1], exp_px[1]};
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL model_t4 t=%0t got=%h want=%h", $time, act, want);
        end
        if (p4.pix_valid_o === 1'b1 && (p4.R | p4.G | p4.B) != 4'd0) lit4[exp_code[1]]++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic chk(string name, int act, int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", name, act, want);
        end
    endtask

    task automatic drive3(bit v, int code, int x, int y);
        p3.pix_valid_i = v;
        p3.tile_code   = 4'(code);
        p3.sx          = 3'(x);
        p3.sy          = 3'(y);
    endtask

    task automatic drive4(bit v, int code, int x, int y);
        p4.pix_valid_i = v;
        p4.tile_code   = 4'(code);
        p4.sx          = 4'(x);
        p4.sy          = 4'(y);
    endtask

    task automatic step(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        step(1);
        frame_start = 1'b0;
    endtask

    int vseq [5] = '{1, 0, 1, 0, 0};
    int oseq [5] = '{0, 0, 1, 0, 1};

    initial begin
        rst = 1'b1; frame_start = 1'b0; gate_open = 1'b0;
        drive3(0, 8, 0, 0);
        drive4(0, 8, 0, 0);
        for (int i = 0; i < 16; i++) begin lit3[i] = 0; lit4[i] = 0; end

        // Reset state
        step(3);
        chk("rst_vld3", int'(p3.pix_valid_o), 0);
        chk("rst_rgb3", int'({p3.R, p3.G, p3.B, p3.wall_px}), 0);
        chk("rst_vld4", int'(p4.pix_valid_o), 0);
        chk("rst_blink_on", int'(dut3.blink_on), 1);
        rst = 1'b0;

        // Power cookie centre, visible two clocks later
        drive3(1, 'hA, 4, 4); step(1);
        drive3(0, 8, 0, 0);   step(1);
        chk("cookie_vld", int'(p3.pix_valid_o), 1);
        chk("cookie_B", int'(p3.B), 15);
        chk("cookie_RG", int'({p3.R, p3.G}), 0);
        chk("cookie_wall", int'(p3.wall_px), 0);

        // Full 8x8 sweep of codes 0x0-0xB
        for (int c = 0; c < 12; c++) begin
            base3[c] = lit3[c];
            for (int y = 0; y < 8; y++)
                for (int x = 0; x < 8; x++) begin
                    drive3(1, c, x, y); step(1);
                end
        end
        drive3(0, 8, 0, 0); step(3);
        chk("cnt3_ll",     lit3[0]  - base3[0],  8);
        chk("cnt3_up",     lit3[1]  - base3[1],  8);
        chk("cnt3_empty",  lit3[8]  - base3[8],  0);
        chk("cnt3_candy",  lit3[9]  - base3[9],  4);
        chk("cnt3_cookie", lit3[10] - base3[10], 9);
        chk("cnt3_gate",   lit3[11] - base3[11], 8);

        // Gate drawn vs hidden
        gate_open = 1'b0;
        drive3(1, 'hB, 0, 4); step(1);
        drive3(0, 8, 0, 0);   step(1);
        chk("gate_R", int'(p3.R), 15);
        chk("gate_B", int'(p3.B), 7);
        chk("gate_wall", int'(p3.wall_px), 1);
        gate_open = 1'b1;
        drive3(1, 'hB, 0, 4); step(1);
        drive3(0, 8, 0, 0);   step(1);
        chk("gate_open_rgb", int'({p3.R, p3.G, p3.B}), 0);
        chk("gate_open_wall", int'(p3.wall_px), 0);
        gate_open = 1'b0;

        // Valid pattern 1,0,1 through the pipe
        step(2);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("vseq%0d", i), int'(p3.pix_valid_o), oseq[i]);
            if (i == 3) chk("bubble_rgb", int'({p3.R, p3.G, p3.B}), 0);
            if (i == 4) chk("vseq_B", int'(p3.B), 15);
            drive3(vseq[i] != 0, 1, 0, 4);
            step(1);
        end

        // Blink with a 2-frame phase; second pulse coincides with a cookie in S2
        pulse_frame();
        drive3(1, 'hA, 4, 4); step(1);
        drive3(1, 'hA, 4, 4); frame_start = 1'b1; step(1);
        drive3(0, 8, 0, 0);   frame_start = 1'b0;
        chk("blink_pre_update", int'(p3.B), 15);
        step(1);
        chk("blink_dark_vld", int'(p3.pix_valid_o), 1);
        chk("blink_dark_B", int'(p3.B), 0);
        drive3(1, 9, 3, 3); step(1);
        drive3(0, 8, 0, 0); step(1);
        chk("candy_during_dark", int'(p3.G), 15);
        pulse_frame();
        pulse_frame();
        drive3(1, 'hA, 3, 5); step(1);
        drive3(0, 8, 0, 0);   step(1);
        chk("blink_relit", int'(p3.B), 15);

        // Reset with pixels in flight; blink back to visible
        pulse_frame();
        pulse_frame();
        drive3(1, 1, 0, 4); step(1);
        drive3(1, 1, 1, 4); step(1);
        rst = 1'b1; drive3(0, 8, 0, 0); step(1);
        rst = 1'b0;
        chk("rst_drop1", int'(p3.pix_valid_o), 0);
        step(1);
        chk("rst_drop2", int'(p3.pix_valid_o), 0);
        chk("rst_blink_restart", int'(dut3.blink_on), 1);

        // Full 16x16 sweep on the wider tile
        for (int c = 0; c < 12; c++) begin
            base4[c] = lit4[c];
            for (int y = 0; y < 16; y++)
                for (int x = 0; x < 16; x++) begin
                    drive4(1, c, x, y); step(1);
                end
        end
        drive4(0, 8, 0, 0); step(3);
        chk("cnt4_ll",     lit4[0]  - base4[0],  16);
        chk("cnt4_up",     lit4[1]  - base4[1],  16);
        chk("cnt4_candy",  lit4[9]  - base4[9],  4);
        chk("cnt4_cookie", lit4[10] - base4[10], 9);

        step(1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
